alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor of the 32-bit ripple ALU in the datapath.
- Width is configurable. Inputs and outputs use a valid/ready handshake.
- Keeps the ALU_control/bonus_control encoding and the zero/cout/overflow flags.
- Adds signed compare modes, NAND, and an iterative unsigned multiply, so the multi-cycle execute stage can stall on it.

Parameters:
WIDTH, 32, operand/result width; legal range 4..64.
MUL_EN, 1, 1 = multiply op implemented; 0 = multiply opcode treated as undefined.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset; asynchronous, active-low.
in_valid  input  1  operands and control presented.
in_ready  output  1  block can accept an operation this cycle.
src1  input  WIDTH  operand A.
src2  input  WIDTH  operand B.
ALU_control  input  4  operation select.
bonus_control  input  3  compare sub-mode, used only by SET.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer takes the result.
result  output  WIDTH  registered result.
zero  output  1  result == 0.
cout  output  1  carry out of the adder.
overflow  output  1  signed add/sub overflow, or unsigned multiply overflow.
busy  output  1  multiply iteration in progress.

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE; counter is cleared.
  - result, zero, cout, overflow, out_valid and busy all go to 0; in_ready goes to 1.
  - Reset mid-multiply aborts the operation; nothing is output.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A + ~B + 1); 1100 NOR; 1101 NAND.
  - 0111 SET; 1000 MUL. Any other code gives result 0 and all flags 0.
- SET, per bonus_control:
  - 000 slt, 001 sgt, 010 sle, 011 sge, 100 seq, 101 sne. 110/111 behave as slt.
  - Signed less = sum[WIDTH-1] XOR ovf of A-B.
  - Result is {WIDTH-1 zeros, bit}.
- Flags:
  - ADD/SUB/SET: cout = carry out of bit WIDTH-1 of the add or subtract; overflow = signed overflow of that operation.
  - Logic ops: cout = 0, overflow = 0.
  - MUL: cout = 0; overflow = 1 if the upper WIDTH bits of the 2*WIDTH-bit product are nonzero.
  - zero = (result == 0) for every op, registered together with result.
- Handshake:
  - in_ready = (state == IDLE) AND (!out_valid OR out_ready).
  - An operation is accepted on in_valid AND in_ready.
  - Output holds stable while out_valid AND !out_ready.
  - out_valid clears on out_valid AND out_ready, unless a new result loads in that same cycle.
  - Accept and drain in the same cycle are allowed and give full throughput: 1 op/cycle for single-cycle ops.
- Latency:
  - Single-cycle ops: out_valid rises the cycle after acceptance.
  - MUL: shift-add, one multiplier bit per cycle. out_valid rises WIDTH+1 cycles after acceptance.
  - busy is high for exactly WIDTH cycles.
- States:
  - IDLE, then on accept of MUL go to MUL. Counter = 0; operands and a 2*WIDTH accumulator are latched.
  - MUL to DONE when the counter reaches WIDTH-1. DONE loads the result and flags, sets out_valid, and returns to IDLE the same cycle.
  - No accept while in MUL or DONE.
- Operands are captured at accept; later changes on src1/src2/control have no effect.
- Arithmetic wraps modulo 2^WIDTH.
- With MUL_EN = 0, opcode 1000 takes the undefined-op path with 1-cycle latency.

Test Plan:
- Reset mid-MUL at cycle 5 → in the reset cycle out_valid = 0, busy = 0, in_ready = 1; no result emitted afterwards.
- ADD 0x7FFFFFFF + 1 → result 0x80000000, overflow = 1, cout = 0, zero = 0, out_valid 1 cycle after accept.
- SUB 5 - 5 → result 0, zero = 1, cout = 1, overflow = 0.
- SET slt -1 vs 1 → 1. sge -1 vs 1 → 0. seq 7 vs 7 → 1. sle 0x80000000 vs 0x7FFFFFFF → 1.
- MUL 0x10000 * 0x10000 → result 0, overflow = 1, zero = 1, out_valid at accept+33, busy for 32 cycles, in_ready = 0 throughout.
- Back-to-back ADDs with out_ready held 0 for 3 cycles → the first result holds stable and in_ready = 0. When out_ready rises, the second op is accepted the same cycle; no ops are lost or duplicated. Repeat with WIDTH = 8: 200 + 100 → result 44, cout = 1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered, width-parameterised ALU with a valid/ready handshake on
// both sides. Logic, add/sub and compare ops complete in one cycle. MUL is an
// iterative shift-add that consumes one multiplier bit per cycle.
//
// Handshake: an op is taken when in_valid && in_ready; a result is taken when
// out_valid && out_ready. in_ready is high only in IDLE when the output slot is
// empty or being drained this same cycle. While out_valid && !out_ready, the
// result and flags hold. A new single-cycle result may load in the drain cycle,
// which gives one op per cycle.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  input  logic [2:0]       bonus_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  // MUL hands over to DONE after bit WIDTH-2; DONE folds in the last bit.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SET  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q, acc_nxt;
  logic [WIDTH-1:0]     mplier_q;

  logic                 accept, is_mul, drain;
  logic                 sub_op, add_ovf, less, equal, set_bit, def_c;
  logic [WIDTH-1:0]     opb;
  logic [WIDTH:0]       add_full;
  logic [WIDTH-1:0]     res_c;
  logic                 cout_c, ovf_c, zero_c;

  assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign is_mul   = MUL_EN && (ALU_control == OP_MUL);
  assign busy     = (state_q == S_MUL) || (state_q == S_DONE);

  // Shared adder: SUB and SET run as A + ~B + 1.
  always_comb begin
    sub_op   = (ALU_control == OP_SUB) || (ALU_control == OP_SET);
    opb      = sub_op ? ~src2 : src2;
    add_full = {1'b0, src1} + {1'b0, opb} + {{WIDTH{1'b0}}, sub_op};
    add_ovf  = (src1[WIDTH-1] == opb[WIDTH-1]) && (add_full[WIDTH-1] != src1[WIDTH-1]);
    less     = add_full[WIDTH-1] ^ add_ovf;
    equal    = (src1 == src2);
  end

  // Compare sub-mode select; 110/111 fall back to slt.
  always_comb begin
    set_bit = less;
    case (bonus_control)
      3'b001:  set_bit = !less && !equal;
      3'b010:  set_bit = less || equal;
      3'b011:  set_bit = !less;
      3'b100:  set_bit = equal;
      3'b101:  set_bit = !equal;
      default: set_bit = less;
    endcase
  end

  // Single-cycle result and flags; unknown opcodes give all zeros.
  always_comb begin
    res_c  = '0;
    cout_c = 1'b0;
    ovf_c  = 1'b0;
    def_c  = 1'b1;
    case (ALU_control)
      OP_AND:  res_c = src1 & src2;
      OP_OR:   res_c = src1 | src2;
      OP_NOR:  res_c = ~(src1 | src2);
      OP_NAND: res_c = ~(src1 & src2);
      OP_ADD, OP_SUB: begin
        res_c  = add_full[WIDTH-1:0];
        cout_c = add_full[WIDTH];
        ovf_c  = add_ovf;
      end
      OP_SET: begin
        res_c  = {{(WIDTH-1){1'b0}}, set_bit};
        cout_c = add_full[WIDTH];
        ovf_c  = add_ovf;
      end
      default: def_c = 1'b0;
    endcase
    zero_c = def_c && (res_c == '0);
  end

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: IDLE -> MUL on multiply accept, MUL -> DONE on last counted bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Multiply datapath: latch operands on accept, then one shift-add per cycle.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (accept && is_mul) begin
        cnt_q    <= '0;
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, src1};
        mplier_q <= src2;
      end
    end else begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  // Output slot: load from DONE or a single-cycle accept, else clear on drain.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (state_q == S_DONE) begin
      result    <= acc_nxt[WIDTH-1:0];
      zero      <= (acc_nxt[WIDTH-1:0] == '0);
      cout      <= 1'b0;
      overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
      out_valid <= 1'b1;
    end else if (accept && !is_mul) begin
      result    <= res_c;
      zero      <= zero_c;
      cout      <= cout_c;
      overflow  <= ovf_c;
      out_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule
